// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: replay modes, FSM encoding and
// a constant-evaluable ceil(log2) used for pointer/count widths.
package uart_pkg;

  localparam logic [1:0] MODE_ECHO = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_SINK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } echo_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with fall-through read data (dout shows the head word
// whenever the FIFO is not empty). Storage is not reset; only pointers and
// occupancy are.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_BITS-1:0]  din,
  output logic [DATA_BITS-1:0]  dout,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 wr_en;
  logic                 rd_en;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered echo engine between uart_rx and uart_tx. Received words are queued
// and replayed one frame at a time with a runtime-selected transform; status
// counters track echoes, drops and transmitter timeouts.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [DATA_BITS-1:0]  rx_data,
  input  logic                  rx_err,
  input  logic [1:0]            mode,
  input  logic                  clr_stats,
  output logic                  tx_start,
  output logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_done,
  output logic [clog2(DEPTH):0] fifo_count,
  output logic [15:0]           echo_count,
  output logic [7:0]            drop_count,
  output logic                  overflow,
  output logic                  tx_timeout
);

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 ovf_drop;
  logic                 echo_inc;
  logic                 tmo_fire;

  echo_state_e          state_q;
  logic                 tx_start_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic [31:0]          timer_q;
  logic [31:0]          gap_q;

  logic [15:0] echo_q, echo_d;
  logic [7:0]  drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;

  function automatic logic [DATA_BITS-1:0] bit_rev(input logic [DATA_BITS-1:0] d);
    logic [DATA_BITS-1:0] r;
    for (int i = 0; i < DATA_BITS; i++) r[i] = d[DATA_BITS-1-i];
    return r;
  endfunction

  function automatic logic [DATA_BITS-1:0] xform(input logic [DATA_BITS-1:0] d,
                                                 input logic [1:0] m);
    case (m)
      MODE_INV:  return ~d;
      MODE_REV:  return bit_rev(d);
      MODE_ECHO: return d;
      default:   return d;
    endcase
  endfunction

  // Words leave the FIFO in LOAD, or directly from IDLE when sinking.
  assign pop      = (state_q == ST_LOAD) ||
                    (state_q == ST_IDLE && !fifo_empty && mode == MODE_SINK);
  assign push     = rx_done && !rx_err && (!fifo_full || pop);
  assign drop     = rx_done && (rx_err || (fifo_full && !pop));
  assign ovf_drop = rx_done && !rx_err && fifo_full && !pop;
  assign echo_inc = (state_q == ST_WAIT_DONE) && tx_done;
  assign tmo_fire = (state_q == ST_WAIT_DONE) && !tx_done &&
                    (timer_q == 32'(TIMEOUT - 1));

  uart_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Replay sequencer. IDLE also reacts to a word being pushed this cycle so a
  // reception into an empty, idle buffer is popped on the very next cycle.
  // The START cycle counts as the first waited cycle of the timeout window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((!fifo_empty || push) && mode != MODE_SINK) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (mode == MODE_SINK) begin
            state_q <= ST_IDLE;
          end else begin
            tx_data_q  <= xform(fifo_dout, mode);
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          timer_q <= 32'd1;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            gap_q   <= '0;
            state_q <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else if (tmo_fire) begin
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ST_GAP: begin
          if (gap_q == 32'(GAP_CYCLES - 1)) state_q <= ST_IDLE;
          else                              gap_q   <= gap_q + 32'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Statistics next-state; a clear in the same cycle as an event wins.
  always_comb begin
    echo_d = echo_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    tmo_d  = tmo_q;
    if (echo_inc)                 echo_d = echo_q + 16'd1;
    if (drop && drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
    if (ovf_drop)                 ovf_d  = 1'b1;
    if (tmo_fire)                 tmo_d  = 1'b1;
    if (clr_stats) begin
      echo_d = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
      tmo_d  = 1'b0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      echo_q <= echo_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign echo_count = echo_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;
  assign tx_timeout = tmo_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: instance A (DEPTH 16, GAP 2) covers
// echo, burst queuing, transforms and drops; instance B (DEPTH 4, GAP 0,
// TIMEOUT 100) covers overflow, timeout and reset during a frame.
module tb_uart_echo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       a_reset, a_rx_done, a_rx_err, a_clr, a_tx_done, a_tx_start;
  logic [7:0] a_rx_data, a_tx_data, a_drop_count;
  logic [1:0] a_mode;
  logic [4:0] a_fifo_count;
  logic [15:0] a_echo_count;
  logic       a_overflow, a_tx_timeout;

  logic       b_reset, b_rx_done, b_rx_err, b_clr, b_tx_done, b_tx_start;
  logic [7:0] b_rx_data, b_tx_data, b_drop_count;
  logic [1:0] b_mode;
  logic [2:0] b_fifo_count;
  logic [15:0] b_echo_count;
  logic       b_overflow, b_tx_timeout;

  uart_echo_buffer #(.DATA_BITS(8), .DEPTH(16), .GAP_CYCLES(2), .TIMEOUT(2000)) u_a (
    .clk(clk), .reset(a_reset), .rx_done(a_rx_done), .rx_data(a_rx_data),
    .rx_err(a_rx_err), .mode(a_mode), .clr_stats(a_clr), .tx_start(a_tx_start),
    .tx_data(a_tx_data), .tx_done(a_tx_done), .fifo_count(a_fifo_count),
    .echo_count(a_echo_count), .drop_count(a_drop_count), .overflow(a_overflow),
    .tx_timeout(a_tx_timeout)
  );

  uart_echo_buffer #(.DATA_BITS(8), .DEPTH(4), .GAP_CYCLES(0), .TIMEOUT(100)) u_b (
    .clk(clk), .reset(b_reset), .rx_done(b_rx_done), .rx_data(b_rx_data),
    .rx_err(b_rx_err), .mode(b_mode), .clr_stats(b_clr), .tx_start(b_tx_start),
    .tx_data(b_tx_data), .tx_done(b_tx_done), .fifo_count(b_fifo_count),
    .echo_count(b_echo_count), .drop_count(b_drop_count), .overflow(b_overflow),
    .tx_timeout(b_tx_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] burst [10];
  logic [7:0] bw [6];
  int peak, cnt, seen;

  initial begin
    burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h55;
    burst[5] = 8'hAA; burst[6] = 8'h12; burst[7] = 8'h87; burst[8] = 8'h39; burst[9] = 8'hE4;
    bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33; bw[3] = 8'h44; bw[4] = 8'h55; bw[5] = 8'h66;

    a_reset = 1; a_rx_done = 0; a_rx_err = 0; a_clr = 0; a_tx_done = 0; a_rx_data = 0; a_mode = 0;
    b_reset = 1; b_rx_done = 0; b_rx_err = 0; b_clr = 0; b_tx_done = 0; b_rx_data = 0; b_mode = 0;
    tick(); tick();
    chk("a_rst_tx_start", a_tx_start, 0);
    chk("a_rst_tx_data", a_tx_data, 0);
    chk("a_rst_fifo", a_fifo_count, 0);
    chk("a_rst_echo", a_echo_count, 0);
    chk("a_rst_drop", a_drop_count, 0);
    chk("a_rst_ovf", a_overflow, 0);
    chk("a_rst_tmo", a_tx_timeout, 0);
    chk("b_rst_fifo", b_fifo_count, 0);
    a_reset = 0; b_reset = 0;
    repeat (2) tick();

    // Single word echo: start two cycles after rx_done.
    a_rx_data = 8'hA5; a_rx_done = 1; tick(); a_rx_done = 0;
    chk("single_fifo_n1", a_fifo_count, 1);
    chk("single_start_n1", a_tx_start, 0);
    tick();
    chk("single_start_n2", a_tx_start, 1);
    chk("single_data_n2", a_tx_data, 8'hA5);
    chk("single_fifo_n2", a_fifo_count, 0);
    tick();
    chk("single_start_n3", a_tx_start, 0);
    repeat (5) tick();
    chk("single_echo_before", a_echo_count, 0);
    a_tx_done = 1; tick(); a_tx_done = 0;
    chk("single_echo_after", a_echo_count, 1);
    repeat (5) tick();

    // Burst of ten words while the transmitter is slow.
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      a_rx_data = burst[i]; a_rx_done = 1; tick();
      if (int'(a_fifo_count) > peak) peak = int'(a_fifo_count);
      if (i == 1) begin
        chk("burst_first_start", a_tx_start, 1);
        chk("burst_first_data", a_tx_data, burst[0]);
      end
    end
    a_rx_done = 0;
    chk("burst_peak", peak, 9);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        cnt = 1;
        while (!a_tx_start && cnt < 40) begin tick(); cnt++; end
        chk("burst_gap_latency", cnt, 5);
        chk("burst_data", a_tx_data, burst[i]);
      end
      repeat (1000) tick();
      a_tx_done = 1; tick(); a_tx_done = 0;
    end
    repeat (10) tick();
    chk("burst_fifo_end", a_fifo_count, 0);
    chk("burst_echo", a_echo_count, 11);
    chk("burst_drop", a_drop_count, 0);

    // Transforms.
    a_mode = 2'b01; a_rx_data = 8'h3C; a_rx_done = 1; tick(); a_rx_done = 0; tick();
    chk("inv_start", a_tx_start, 1);
    chk("inv_data", a_tx_data, 8'hC3);
    repeat (3) tick(); a_tx_done = 1; tick(); a_tx_done = 0; repeat (5) tick();
    a_mode = 2'b10; a_rx_data = 8'h12; a_rx_done = 1; tick(); a_rx_done = 0; tick();
    chk("rev_start", a_tx_start, 1);
    chk("rev_data", a_tx_data, 8'h48);
    repeat (3) tick(); a_tx_done = 1; tick(); a_tx_done = 0; repeat (5) tick();
    // Mode is taken at pop time, one cycle after rx_done.
    a_mode = 2'b10; a_rx_data = 8'h0F; a_rx_done = 1; tick(); a_rx_done = 0; a_mode = 2'b00; tick();
    chk("popmode_data", a_tx_data, 8'h0F);
    repeat (3) tick(); a_tx_done = 1; tick(); a_tx_done = 0; repeat (5) tick();
    chk("mode_echo_count", a_echo_count, 14);
    a_mode = 2'b11; a_rx_data = 8'h55; a_rx_done = 1; tick(); a_rx_done = 0;
    chk("sink_fifo_n1", a_fifo_count, 1);
    seen = 0;
    repeat (10) begin tick(); if (a_tx_start) seen++; end
    chk("sink_no_start", seen, 0);
    chk("sink_fifo_drained", a_fifo_count, 0);
    chk("sink_echo", a_echo_count, 14);
    a_mode = 2'b00;

    // Errored reception is dropped without overflow; clear beats a same-cycle drop.
    a_rx_err = 1; a_rx_data = 8'h87; a_rx_done = 1; tick(); a_rx_done = 0; a_rx_err = 0;
    chk("err_fifo", a_fifo_count, 0);
    chk("err_drop", a_drop_count, 1);
    chk("err_ovf", a_overflow, 0);
    a_rx_err = 1; a_rx_done = 1; a_clr = 1; tick(); a_rx_done = 0; a_rx_err = 0; a_clr = 0;
    chk("clr_drop", a_drop_count, 0);
    chk("clr_echo", a_echo_count, 0);

    // Overflow on the shallow instance.
    for (int i = 0; i < 6; i++) begin
      b_rx_data = bw[i]; b_rx_done = 1; tick();
      if (i == 1) begin
        chk("b_first_start", b_tx_start, 1);
        chk("b_first_data", b_tx_data, 8'h11);
      end
    end
    b_rx_done = 0;
    chk("b_ovf_fifo", b_fifo_count, 4);
    chk("b_ovf_drop", b_drop_count, 1);
    chk("b_ovf_flag", b_overflow, 1);
    // Now at start+4; timeout lands at start+100.
    repeat (95) tick();
    chk("b_tmo_early", b_tx_timeout, 0);
    tick();
    chk("b_tmo_set", b_tx_timeout, 1);
    chk("b_tmo_echo", b_echo_count, 0);
    tick(); tick();
    chk("b_next_start", b_tx_start, 1);
    chk("b_next_data", b_tx_data, 8'h22);
    b_clr = 1; tick(); b_clr = 0;
    chk("b_clr_drop", b_drop_count, 0);
    chk("b_clr_ovf", b_overflow, 0);
    chk("b_clr_tmo", b_tx_timeout, 0);
    chk("b_clr_fifo", b_fifo_count, 3);
    repeat (3) tick();
    b_tx_done = 1; tick(); b_tx_done = 0;
    chk("b_echo", b_echo_count, 1);
    cnt = 1;
    while (!b_tx_start && cnt < 40) begin tick(); cnt++; end
    chk("b_gap0_latency", cnt, 3);
    chk("b_gap0_data", b_tx_data, 8'h33);

    // Reset while waiting for tx_done.
    repeat (2) tick();
    b_reset = 1; tick(); b_reset = 0;
    chk("b_rst_tx_start", b_tx_start, 0);
    chk("b_rst_tx_data", b_tx_data, 0);
    chk("b_rst_fifo", b_fifo_count, 0);
    chk("b_rst_echo", b_echo_count, 0);
    chk("b_rst_drop", b_drop_count, 0);
    chk("b_rst_ovf", b_overflow, 0);
    chk("b_rst_tmo", b_tx_timeout, 0);
    b_tx_done = 1; tick(); b_tx_done = 0;
    seen = 0;
    repeat (5) begin tick(); if (b_tx_start) seen++; end
    chk("b_late_done_echo", b_echo_count, 0);
    chk("b_late_done_start", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Buffered, parametrised echo engine placed between a `uart_rx` and a `uart_tx` inside `uart_top`. Received words are queued in a FIFO and replayed to the transmitter one frame at a time, so back-to-back receptions are not lost while the transmitter is busy. A runtime mode selects the replay transform, and status counters report echoes, overflow drops and transmitter timeouts.

## Interface
- `DATA_BITS`, 8: word width, range 5..9.
- `DEPTH`, 16: FIFO depth; power of two, minimum 2.
- `GAP_CYCLES`, 0: idle clk cycles inserted after each `tx_done` before the next `tx_start`.
- `TIMEOUT`, 2_000_000: max clk cycles waiting for `tx_done` before abandoning a frame.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rx_done` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in DATA_BITS: received word.
- `rx_err` in 1: framing/parity error qualifier, sampled with `rx_done`.
- `mode` in 2: 00 echo, 01 invert, 10 bit-reverse, 11 sink.
- `clr_stats` in 1: clears counters and sticky flags.
- `tx_start` out 1: one-cycle start strobe to `uart_tx`.
- `tx_data` out DATA_BITS: word to transmit; stable from `tx_start` until `tx_done`.
- `tx_done` in 1: one-cycle completion strobe from `uart_tx`.
- `fifo_count` out clog2(DEPTH)+1: current occupancy.
- `echo_count` out 16: completed echoes, wraps modulo 2^16.
- `drop_count` out 8: dropped words (overflow or `rx_err`), saturates at 255.
- `overflow` out 1: sticky, set on any overflow drop.
- `tx_timeout` out 1: sticky, set on timeout.

## Operation
- Push: `rx_done` && !`rx_err` && (not full || pop in same cycle). `rx_done` && `rx_err`: word discarded, `drop_count`+1. `rx_done` while full and no pop: word discarded, `drop_count`+1, `overflow` set.
- FSM states: IDLE, LOAD, START, WAIT_DONE, GAP.
  - IDLE: when not empty, pop. If `mode`=11, the word is discarded and the FSM stays in IDLE (one word per cycle). Otherwise go to LOAD.
  - LOAD: `tx_data` <= transform(popped word). The transform is the `mode` value sampled at pop time. Go to START.
  - START: `tx_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_DONE.
  - WAIT_DONE: on `tx_done`, `echo_count`+1, then go to GAP if `GAP_CYCLES`>0, else IDLE. If the counter reaches `TIMEOUT` first, set `tx_timeout` and go to IDLE with no echo counted.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- `tx_done` outside WAIT_DONE is ignored.
- Transforms:
  - invert: bitwise NOT over DATA_BITS.
  - bit-reverse: bit i -> bit DATA_BITS-1-i.
- `clr_stats`: zeroes `echo_count` and `drop_count`, clears both stickies. It does not affect the FIFO or the FSM. If `clr_stats` and a drop occur in the same cycle, clear wins.
- Reset: FIFO flushed, FSM to IDLE, all outputs 0. An in-flight `uart_tx` frame is not aborted by this block; a `tx_done` arriving after reset is ignored.

## Timing
- `rx_done` at cycle N:
  - `fifo_count` increments at N+1.
  - If the FSM is idle and the FIFO was empty: pop at N+1, `tx_data` valid at N+2, `tx_start` high during cycle N+2 (registered, 2-cycle latency).
- Next `tx_start`:
  - `GAP_CYCLES`=0: 3 cycles after `tx_done`.
  - `GAP_CYCLES`=G: G+3 cycles after `tx_done`.
- `fifo_count` is registered. It reflects push/pop of the previous cycle. A simultaneous push and pop leaves it unchanged.
- The FIFO read pointer and write pointer wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.

## Structure
- Package `uart_pkg`:
  - mode constants `MODE_ECHO`, `MODE_INV`, `MODE_REV`, `MODE_SINK`.
  - FSM state encoding.
  - function `clog2`.
- Sub-module `uart_sync_fifo`:
  - parameters DATA_BITS, DEPTH.
  - ports: push, pop, din, dout, count, full, empty.
  - same clk/reset.
- Transform logic and counters stay in `uart_echo_buffer`.

## Test plan
- Single word, `mode`=00: `rx_data`=0xA5 -> one `tx_start` 2 cycles after `rx_done` with `tx_data`=0xA5; `echo_count`=1 after `tx_done`.
- Burst of 10 words (A5,3C,FF,00,55,AA,12,87,39,E4) while `tx_done` is held off 1000 cycles per frame -> all 10 echoed in order; `drop_count`=0; `fifo_count` peaks at 9.
- `DEPTH`=4, 6 words with no `tx_done` -> first word in flight, next 4 queued, 6th dropped; `overflow`=1, `drop_count`=1; `clr_stats` returns both to 0.
- `mode` sequence (8-bit):
  - `mode`=01 with 0x3C -> `tx_data`=0xC3.
  - `mode`=10 with 0x12 -> 0x48.
  - `mode`=11 with 0x55 -> no `tx_start`; FIFO drains; `echo_count` unchanged.
- `rx_err`=1 with 0x87 -> not queued; `drop_count`=1; `overflow`=0.
- `TIMEOUT`=100, `tx_done` never asserted -> `tx_timeout`=1 at `tx_start`+100; FSM services the next queued word. Assert `reset` during WAIT_DONE -> all outputs 0 next cycle, `fifo_count`=0.
